// File: rtl/hazard_ctrl.sv
// Hazard controller at the ID/EX boundary: load-use stalls, branch flushes and data-memory wait states.
// Optional macro HAZARD_STALL_COUNT_EN builds a saturating counter of cycles with the PC frozen.
module hazard_ctrl #(
  parameter int REG_W             = 16,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 3
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [REG_W-1:0] IDRs1,
  input  logic [REG_W-1:0] IDRs2,
  input  logic             IDUsesRs2,
  input  logic             EXMemRead,
  input  logic             EXRegWrite,
  input  logic [REG_W-1:0] EXRd,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXBubble,
  output logic             IDEXWrite,
  output logic             EXMEMHold,
  output logic [1:0]       State,
  output logic [15:0]      StallCount
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_RELOAD  = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state;
  state_t           saved_state;
  state_t           active_state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             load_use;
  logic             mem_wait;
  logic             flush_out;
  logic             stall_out;

  assign load_use = EXMemRead & EXRegWrite & (EXRd != '0) &
                    ((EXRd == IDRs1) | (IDUsesRs2 & (EXRd == IDRs2)));
  assign mem_wait = MemReq & ~MemReady;

  // While waiting on memory the interrupted state is what decides behaviour on release.
  assign active_state = (state == MEM_WAIT) ? saved_state : state;
  assign State        = state;

  always_comb begin
    flush_out  = 1'b0;
    stall_out  = 1'b0;
    next_state = RUN;
    next_cnt   = '0;
    unique case (active_state)
      LOAD_USE: begin
        if (BranchTaken) begin
          flush_out = 1'b1;
        end else begin
          stall_out = 1'b1;
          if (cnt > CNT_ONE) begin
            next_state = LOAD_USE;
            next_cnt   = cnt - CNT_ONE;
          end
        end
      end
      FLUSH: begin
        flush_out = 1'b1;
        if (!BranchTaken && cnt > CNT_ONE) begin
          next_state = FLUSH;
          next_cnt   = cnt - CNT_ONE;
        end
      end
      default: begin
        if (BranchTaken) begin
          flush_out = 1'b1;
        end else if (load_use) begin
          stall_out = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            next_state = LOAD_USE;
            next_cnt   = LOAD_RELOAD;
          end
        end
      end
    endcase
    // Any taken branch restarts the flush window, whatever was in progress.
    if (BranchTaken && FLUSH_CYCLES > 1) begin
      next_state = FLUSH;
      next_cnt   = FLUSH_RELOAD;
    end
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    IDEXWrite  = 1'b1;
    EXMEMHold  = 1'b0;
    if (Reset) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (mem_wait) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMHold  = 1'b1;
    end else if (flush_out) begin
      IFIDFlush  = 1'b1;
      IDEXBubble = 1'b1;
    end else if (stall_out) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXBubble = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state       <= RUN;
      saved_state <= RUN;
      cnt         <= '0;
    end else if (mem_wait) begin
      // Counter stays frozen; only the first wait cycle captures the state to resume.
      if (state != MEM_WAIT) begin
        saved_state <= state;
      end
      state <= MEM_WAIT;
    end else begin
      state       <= next_state;
      saved_state <= RUN;
      cnt         <= next_cnt;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      StallCount <= 16'h0000;
    end else if (!PCWrite && StallCount != 16'hFFFF) begin
      StallCount <= StallCount + 16'd1;
    end
  end
`else
  assign StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (default and multi-cycle penalties) against a
// counter-based reference model, with directed scenarios followed by random traffic.
module tb_hazard_ctrl;

  localparam int REG_W = 16;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] idRs1;
  logic [REG_W-1:0] idRs2;
  logic             idUsesRs2;
  logic             exMemRead;
  logic             exRegWrite;
  logic [REG_W-1:0] exRd;
  logic             branchTaken;
  logic             memReq;
  logic             memReady;

  logic [5:0]  ctrl [2];
  logic [1:0]  stateOut [2];
  logic [15:0] stallOut [2];

  logic pcA, ifidWA, ifidFA, bubA, idexWA, holdA;
  logic pcB, ifidWB, ifidFB, bubB, idexWB, holdB;

  int errors = 0;
  int checks = 0;

  int remStall [2];
  int remFlush [2];
  bit waiting  [2];
  int stallCnt [2];

  hazard_ctrl u_dutA (
    .CLK(clk), .Reset(reset), .IDRs1(idRs1), .IDRs2(idRs2), .IDUsesRs2(idUsesRs2),
    .EXMemRead(exMemRead), .EXRegWrite(exRegWrite), .EXRd(exRd), .BranchTaken(branchTaken),
    .MemReq(memReq), .MemReady(memReady), .PCWrite(pcA), .IFIDWrite(ifidWA), .IFIDFlush(ifidFA),
    .IDEXBubble(bubA), .IDEXWrite(idexWA), .EXMEMHold(holdA), .State(stateOut[0]),
    .StallCount(stallOut[0])
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2)) u_dutB (
    .CLK(clk), .Reset(reset), .IDRs1(idRs1), .IDRs2(idRs2), .IDUsesRs2(idUsesRs2),
    .EXMemRead(exMemRead), .EXRegWrite(exRegWrite), .EXRd(exRd), .BranchTaken(branchTaken),
    .MemReq(memReq), .MemReady(memReady), .PCWrite(pcB), .IFIDWrite(ifidWB), .IFIDFlush(ifidFB),
    .IDEXBubble(bubB), .IDEXWrite(idexWB), .EXMEMHold(holdB), .State(stateOut[1]),
    .StallCount(stallOut[1])
  );

  // Control bits packed as {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXWrite, EXMEMHold}.
  assign ctrl[0] = {pcA, ifidWA, ifidFA, bubA, idexWA, holdA};
  assign ctrl[1] = {pcB, ifidWB, ifidFB, bubB, idexWB, holdB};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int loadCycles(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int flushCycles(int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic bit hazardNow();
    return exMemRead && exRegWrite && exRd != 0 &&
           (exRd == idRs1 || (idUsesRs2 && exRd == idRs2));
  endfunction

  // Model: pending bubble and flush cycles plus a "waiting on memory" flag.
  function automatic logic [5:0] modelCtrl(int i);
    if (reset) return 6'b001110;
    if (memReq && !memReady) return 6'b000001;
    if (branchTaken || remFlush[i] > 0) return 6'b111110;
    if (remStall[i] > 0 || hazardNow()) return 6'b000110;
    return 6'b110010;
  endfunction

  function automatic logic [1:0] modelState(int i);
    if (waiting[i]) return 2'd3;
    if (remFlush[i] > 0) return 2'd2;
    if (remStall[i] > 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic modelStep(int i);
    logic [5:0] e;
    e = modelCtrl(i);
    if (reset) begin
      remStall[i] = 0;
      remFlush[i] = 0;
      waiting[i]  = 1'b0;
      stallCnt[i] = 0;
    end else begin
      if (memReq && !memReady) begin
        waiting[i] = 1'b1;
      end else begin
        waiting[i] = 1'b0;
        if (branchTaken) begin
          remFlush[i] = flushCycles(i) - 1;
          remStall[i] = 0;
        end else if (remFlush[i] > 0) begin
          remFlush[i] = remFlush[i] - 1;
        end else if (remStall[i] > 0) begin
          remStall[i] = remStall[i] - 1;
        end else if (hazardNow()) begin
          remStall[i] = loadCycles(i) - 1;
        end
      end
      if (!e[5] && stallCnt[i] < 65535) stallCnt[i] = stallCnt[i] + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check before the rising edge, then advance the model.
  task automatic applyStimulus(input logic rst, input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                               input logic uses2, input logic mr, input logic rw,
                               input logic [REG_W-1:0] rd, input logic br, input logic req,
                               input logic rdy);
    logic [15:0] expCount;
    reset = rst; idRs1 = rs1; idRs2 = rs2; idUsesRs2 = uses2;
    exMemRead = mr; exRegWrite = rw; exRd = rd; branchTaken = br;
    memReq = req; memReady = rdy;
    #2;
    for (int i = 0; i < 2; i++) begin
`ifdef HAZARD_STALL_COUNT_EN
      expCount = 16'(stallCnt[i]);
`else
      expCount = 16'h0000;
`endif
      checkOutput($sformatf("ctrl%0d", i), 32'(ctrl[i]), 32'(modelCtrl(i)));
      checkOutput($sformatf("state%0d", i), 32'(stateOut[i]), 32'(modelState(i)));
      checkOutput($sformatf("stallcount%0d", i), 32'(stallOut[i]), 32'(expCount));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) modelStep(i);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; idRs1 = '0; idRs2 = '0; idUsesRs2 = 1'b0; exMemRead = 1'b0;
    exRegWrite = 1'b0; exRd = '0; branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      remStall[i] = 0; remFlush[i] = 0; waiting[i] = 1'b0; stallCnt[i] = 0;
    end
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Load-use on rs1, then the same pattern against register 0.
    applyStimulus(0, 3, 0, 0, 1, 1, 3, 0, 0, 0);
    idle(3);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(1);

    // Load-use through rs2, then with rs2 unused.
    applyStimulus(0, 1, 5, 1, 1, 1, 5, 0, 0, 0);
    idle(3);
    applyStimulus(0, 1, 5, 0, 1, 1, 5, 0, 0, 0);
    idle(1);

    // Branch together with a load-use hazard.
    applyStimulus(0, 4, 0, 0, 1, 1, 4, 1, 0, 0);
    idle(3);

    // Memory wait of four cycles, released on the fifth.
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);

    // Memory wait arriving in the middle of a multi-cycle load-use stall.
    applyStimulus(0, 6, 0, 0, 1, 1, 6, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);

    // Reset in the middle of a memory wait.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 1, 1, 2, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Random traffic with small register numbers so hazards are frequent.
    for (int k = 0; k < 1500; k++) begin
      applyStimulus(($urandom_range(0, 49) == 0),
                    REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 2) != 0), REG_W'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
